// File: rtl/weight_update_if.sv
// rtl/weight_update_if.sv - control, delta and weight-status signals of weight_update
interface weight_update_if #(
   parameter int EPOCH_W = 8
);
   logic               start;
   logic [15:0]        init_w;
   logic [EPOCH_W-1:0] num_updates;
   logic [15:0]        dcdw;
   logic [15:0]        w;
   logic               w_upd;
   logic               busy;
   logic               done;
   logic [EPOCH_W-1:0] upd_cnt;

   modport master (
      output start, init_w, num_updates, dcdw,
      input  w, w_upd, busy, done, upd_cnt
   );

   modport slave (
      input  start, init_w, num_updates, dcdw,
      output w, w_upd, busy, done, upd_cnt
   );
endinterface

// File: rtl/weight_update.sv
// rtl/weight_update.sv - single trainable weight, w <= sat(w + dcdw) once per batch window
// Optional WEIGHT_CLIP_EN clamps the weight to [-CLIP_MAX, +CLIP_MAX] on load and update.
module weight_update #(
   parameter int BATCH        = 4,
   parameter int SAMPLE_PHASE = 3,
   parameter int EPOCH_W      = 8
`ifdef WEIGHT_CLIP_EN
   ,
   parameter logic signed [15:0] CLIP_MAX = 16'sh2000
`endif
) (
   input  logic             clk,
   input  logic             res,
   weight_update_if.slave   bus
);

   localparam int PW = (BATCH > 1) ? $clog2(BATCH) : 1;
   localparam logic [PW-1:0] PH_LAST   = PW'(BATCH - 1);
   localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PHASE);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t               state, next_state;
   logic [PW-1:0]        phase;
   logic signed [15:0]   w_q;
   logic [EPOCH_W-1:0]   upd_cnt_q;
   logic [EPOCH_W-1:0]   num_lat;
   logic                 w_upd_q;
   logic                 busy_c, done_c;

   logic                 accept_start;
   logic                 sample;
   logic [EPOCH_W-1:0]   cnt_inc;
   logic signed [15:0]   dcdw_s;
   logic signed [16:0]   sum17;
   logic signed [15:0]   w_sat;
   logic signed [15:0]   w_new;
   logic signed [15:0]   w_init;

   function automatic logic signed [15:0] clip(input logic signed [15:0] v);
`ifdef WEIGHT_CLIP_EN
      if (v > CLIP_MAX)
         return CLIP_MAX;
      else if (v < -CLIP_MAX)
         return -CLIP_MAX;
      else
         return v;
`else
      return v;
`endif
   endfunction

   assign accept_start = bus.start && (state == IDLE || state == DONE);
   assign sample       = (state == RUN) && (phase == PH_SAMPLE);
   assign cnt_inc      = (upd_cnt_q == {EPOCH_W{1'b1}}) ? upd_cnt_q : upd_cnt_q + 1'b1;

   // Overflow of the 17-bit sum shows up as disagreement between its top two bits.
   assign dcdw_s = bus.dcdw;
   assign sum17  = 17'(w_q) + 17'(dcdw_s);
   assign w_sat  = (sum17[16] != sum17[15]) ? (sum17[16] ? 16'sh8000 : 16'sh7FFF)
                                            : sum17[15:0];
   assign w_new  = clip(w_sat);
   assign w_init = clip(bus.init_w);

   always_ff @(posedge clk or posedge res) begin
      if (res)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = LOAD;
         LOAD:    next_state = (num_lat == '0) ? DONE : RUN;
         RUN:     if (sample && cnt_inc == num_lat) next_state = DONE;
         DONE:    if (bus.start) next_state = LOAD;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy_c = 1'b0;
      done_c = 1'b0;
      case (state)
         LOAD, RUN: busy_c = 1'b1;
         DONE:      done_c = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         w_q       <= '0;
         upd_cnt_q <= '0;
         num_lat   <= '0;
         phase     <= '0;
         w_upd_q   <= 1'b0;
      end else begin
         w_upd_q <= sample;
         if (accept_start)
            num_lat <= bus.num_updates;
         if (state == LOAD) begin
            w_q       <= w_init;
            upd_cnt_q <= '0;
            phase     <= '0;
         end else if (state == RUN) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            if (sample) begin
               w_q       <= w_new;
               upd_cnt_q <= cnt_inc;
            end
         end
      end
   end

   assign bus.w       = w_q;
   assign bus.w_upd   = w_upd_q;
   assign bus.busy    = busy_c;
   assign bus.done    = done_c;
   assign bus.upd_cnt = upd_cnt_q;

endmodule

// File: tb/tb_weight_update.sv
// tb/tb_weight_update.sv - scoreboard bench for weight_update
module tb_weight_update;

   logic clk = 1'b0;
   logic res = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   start_cyc = 0;
   int   last_cyc = 0;
   bit   first_pulse = 1'b0;
   int   pulses = 0;
   logic [15:0] q[$];
   logic [15:0] exp_final;
   int   exp_n;

   weight_update_if #(.EPOCH_W(8)) bus ();

   weight_update dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_clip(input logic [15:0] v);
`ifdef WEIGHT_CLIP_EN
      int s;
      s = int'($signed(v));
      if (s > 8192) s = 8192;
      if (s < -8192) s = -8192;
      return 16'(s);
`else
      return v;
`endif
   endfunction

   function automatic logic [15:0] model_upd(input logic [15:0] wv, input logic [15:0] d);
      int s;
      s = int'($signed(wv)) + int'($signed(d));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return model_clip(16'(s));
   endfunction

   always @(negedge clk) begin
      if (!res && bus.w_upd) begin
         pulses++;
         if (q.size() == 0)
            check("w_upd_unexpected", 32'd1, 32'd0);
         else
            check("w_after_upd", 32'(bus.w), 32'(q.pop_front()));
         if (first_pulse)
            check("first_upd_latency", 32'(cyc - start_cyc), 32'd6);
         else
            check("upd_spacing", 32'(cyc - last_cyc), 32'd4);
         first_pulse = 1'b0;
         last_cyc = cyc;
      end
   end

   task automatic start_run(input logic [15:0] iw, input logic [7:0] n, input logic [15:0] d);
      logic [15:0] m;
      bus.init_w = iw;
      bus.num_updates = n;
      bus.dcdw = d;
      m = model_clip(iw);
      for (int k = 0; k < int'(n); k++) begin
         m = model_upd(m, d);
         q.push_back(m);
      end
      exp_final = m;
      exp_n = int'(n);
      @(posedge clk); #1;
      bus.start = 1'b1;
      start_cyc = cyc;
      first_pulse = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("busy_in_load", 32'(bus.busy), 32'd1);
      check("done_low_in_load", 32'(bus.done), 32'd0);
   endtask

   task automatic finish_run(input string tag);
      int budget;
      bit seen;
      budget = 4 * exp_n + 20;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen)
         check({tag, "_done_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_upd_cnt"}, 32'(bus.upd_cnt), 32'(exp_n));
      check({tag, "_w_final"}, 32'(bus.w), 32'(exp_final));
      check({tag, "_pending"}, 32'(q.size()), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_w"}, 32'(bus.w), 32'd0);
      check({tag, "_w_upd"}, 32'(bus.w_upd), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_upd_cnt"}, 32'(bus.upd_cnt), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      bit seen;
      bus.start = 1'b0;
      bus.init_w = '0;
      bus.num_updates = '0;
      bus.dcdw = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      res = 1'b0;

      // Reset during phase 2 of batch 2.
      start_run(16'h0400, 8'd5, 16'h0010);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.w_upd) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("midrun_upd_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      res = 1'b1;
      #1;
      check_reset_vals("midrun_reset");
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      res = 1'b0;

      // Basic run, also the fresh run after reset.
      p0 = pulses;
      start_run(16'h0400, 8'd3, 16'hFF9A);
      finish_run("basic");
      check("basic_pulses", 32'(pulses - p0), 32'd3);
      check("basic_w_literal", 32'(bus.w), 32'(model_clip(16'h02CE) == 16'h02CE ? 16'h02CE : exp_final));

      start_run(16'h7F00, 8'd2, 16'h0200);
      finish_run("pos_sat");

      start_run(16'h8100, 8'd1, 16'hFE00);
      finish_run("neg_sat");

      p0 = pulses;
      start_run(16'h1234, 8'd0, 16'h0100);
      finish_run("zero_upd");
      check("zero_upd_pulses", 32'(pulses - p0), 32'd0);

      // Stray start in RUN must not restart the run.
      p0 = pulses;
      start_run(16'h0000, 8'd3, 16'h0040);
      repeat (5) @(posedge clk);
      #1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      finish_run("stray_start");
      check("stray_start_pulses", 32'(pulses - p0), 32'd3);

      start_run(16'h3000, 8'd1, 16'h0100);
      finish_run("clip");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/weight_update.md
Name: weight_update

Overview:
- Downstream consumer of the eta-scaled, batch-summed weight delta (dcdw, Q6.10 signed).
- Holds one trainable weight and applies w <= sat(w + dcdw) once per 4-cycle batch window.
- Counts epochs and raises done after a programmed number of updates.
- Sits between the delta-accumulation stage and the forward-path multiplier that reads w.

Parameters:
- BATCH, 4, batch window length in cycles; phase counter wraps at BATCH-1.
- SAMPLE_PHASE, 3, phase value on which dcdw is sampled and w is updated.
- EPOCH_W, 8, width of the update counter and of num_updates.
- CLIP_MAX, 16'sh2000, positive clip limit (+8.0 in Q6.10); used only with WEIGHT_CLIP_EN.

Ports:
- clk  input  1  system clock, rising edge.
- res  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; loads init_w and begins training.
- init_w  input  16  initial weight, Q6.10 signed.
- num_updates  input  EPOCH_W  number of updates to apply; 0 means none.
- dcdw  input  16  weight delta from upstream, Q6.10 signed.
- w  output  16  current weight, Q6.10 signed.
- w_upd  output  1  one-cycle pulse, high in the cycle after w changed.
- busy  output  1  high in LOAD and RUN.
- done  output  1  high in DONE.
- upd_cnt  output  EPOCH_W  updates applied since last start.

Behaviour:
- Clock and reset: one clock, clk. Reset res is asynchronous and active-high.
- Reset values: state=IDLE, w=0, w_upd=0, busy=0, done=0, upd_cnt=0, phase=0.
- FSM states:
  - IDLE: wait for start. On start go to LOAD.
  - LOAD: one cycle. w<=init_w, upd_cnt<=0, phase<=0. Go to RUN, or to DONE if num_updates==0. num_updates is latched on start.
  - RUN: phase counts 0..BATCH-1 and wraps. When phase==SAMPLE_PHASE: w<=sat16(w+dcdw), upd_cnt++, w_upd pulses next cycle. When the update makes upd_cnt equal the latched num_updates, go to DONE the next cycle.
  - DONE: w holds, done=1. On start go to LOAD. done drops on the LOAD cycle.
- start arriving in LOAD or RUN is ignored. Training cannot be restarted mid-run except by res.
- Arithmetic:
  - 17-bit signed sum of w and dcdw.
  - Result above 16'sh7FFF gives 16'sh7FFF; below 16'sh8000 gives 16'sh8000; otherwise truncate to 16 bits.
  - No rounding.
- Latency: dcdw sampled on the SAMPLE_PHASE edge; w valid one clock later; w_upd coincident with the new w.
- Phase alignment: phase resets to 0 on LOAD. Upstream must release its first valid window so that it coincides with phase==SAMPLE_PHASE of the first RUN batch. Both stages share res.
- Reset mid-RUN: immediate return to reset values. Partial progress is discarded.
- upd_cnt saturates at 2^EPOCH_W-1. It cannot exceed num_updates anyway.

Optional Feature:
- Macro: WEIGHT_CLIP_EN.
- Defined: after 16-bit saturation, w is clamped to [-CLIP_MAX, +CLIP_MAX]. This applies to updates and to the init_w load.
- Not defined: only the 16-bit saturation applies, and init_w is loaded unmodified.

Test Plan:
1. Reset mid-RUN: assert res during phase 2 of batch 2 -> all outputs at reset values same cycle; start afterwards behaves as a fresh run.
2. Basic run: init_w=0x0400 (1.0), num_updates=3, dcdw=0xFF9A (-0.1) constant -> w = 0x039A, 0x0334, 0x02CE on successive updates, 4 cycles apart; three w_upd pulses; done after the third; upd_cnt=3.
3. Positive saturation: init_w=0x7F00, dcdw=0x0200, num_updates=2 -> w=0x7FFF after update 1 and stays 0x7FFF after update 2.
4. Negative saturation: init_w=0x8100, dcdw=0xFE00 -> w=0x8000.
5. num_updates=0: start -> LOAD then DONE; w=init_w, no w_upd, upd_cnt=0. Also: start pulse during RUN is ignored and the run completes unchanged.
6. WEIGHT_CLIP_EN: init_w=0x3000 loads as 0x2000; dcdw=0x0100 keeps w=0x2000. Without the macro: w=0x3000, then 0x3100.
